// File: rtl/pcie_trn_pkg.sv
// Shared definitions for the PCIe TRN receive buffer.
//   BAR_W     : width of the BAR-hit vector carried with every beat
//   state_t   : framing FSM states
//   clog2     : constant ceiling-log2 helper
//   entry_w   : width of one FIFO entry {data, rem, sof, eof, err, bar}
package pcie_trn_pkg;

  localparam int BAR_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int unsigned r;
    r = 0;
    while ((1 << r) < v) r++;
    return int'(r);
  endfunction

  // data + rem (one bit per 64-bit lane) + sof/eof/err + bar
  function automatic int entry_w(input int data_width);
    return data_width + data_width / 64 + 3 + BAR_W;
  endfunction

endpackage

// File: rtl/pcie_trn_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers only)
//   wr_en/wr_data : write port, ignored when full
//   rd_en/rd_data : read port, rd_data is the head entry (combinational)
//   count/full/empty : occupancy status
module pcie_trn_sync_fifo
  import pcie_trn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pcie_trn_rx_buffer.sv
// Receive-side buffer on the PCIe endpoint TRN RX interface (trn_clk domain).
//   trn_*      : active-low TRN receive interface; trn_rdst_rdy_n and
//                trn_rnp_ok_n are registered from FIFO occupancy
//   rx_*       : active-high valid/ready packet stream; fields read 0 when
//                rx_valid=0; rx_err is meaningful on the eof beat
//   tlp_count  : TLPs written with eof (saturating)
//   drop_count : discontinued/truncated TLPs plus stray beats (saturating)
//   occupancy  : current FIFO count
module pcie_trn_rx_buffer
  import pcie_trn_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 16,
  parameter  int NP_THRESH  = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int REM_W      = DATA_WIDTH / 64,
  localparam int CW         = clog2(DEPTH) + 1
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset_n,
  input  logic [DATA_WIDTH-1:0] trn_rd,
  input  logic [REM_W-1:0]      trn_rrem_n,
  input  logic                  trn_rsof_n,
  input  logic                  trn_reof_n,
  input  logic                  trn_rsrc_rdy_n,
  input  logic                  trn_rsrc_dsc_n,
  input  logic                  trn_rerrfwd_n,
  input  logic [6:0]            trn_rbar_hit_n,
  output logic                  trn_rdst_rdy_n,
  output logic                  trn_rnp_ok_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [REM_W-1:0]      rx_rem,
  output logic                  rx_sof,
  output logic                  rx_eof,
  output logic                  rx_err,
  output logic [6:0]            rx_bar,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [CNT_WIDTH-1:0]  tlp_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CW-1:0]         occupancy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [REM_W-1:0]      rem;
    logic                  sof;
    logic                  eof;
    logic                  err;
    logic [BAR_W-1:0]      bar;
  } entry_t;

  localparam int ENTRY_W = entry_w(DATA_WIDTH);

  state_t               state_q, state_n;
  logic [BAR_W-1:0]     bar_q, bar_n;
  logic                 err_q, err_n;
  logic                 replay_q, replay_n;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [REM_W-1:0]     hold_rem;
  logic                 hold_eof, hold_perr;
  logic [BAR_W-1:0]     hold_bar;

  logic                 accept, dsc;
  logic                 b_valid, b_sof, b_eof, b_perr;
  logic [DATA_WIDTH-1:0] b_data;
  logic [REM_W-1:0]     b_rem;
  logic [BAR_W-1:0]     b_bar;

  logic                 wr_en, wr_do, rd_do, tlp_inc, drop_inc;
  entry_t               wr_entry, term, head;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        count_next;

  assign accept = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign dsc    = !trn_rsrc_dsc_n;

  // A sof that arrived without a preceding eof is parked in the hold
  // registers and replayed as a fresh IDLE beat one cycle later, after the
  // terminator for the truncated TLP has taken that cycle's write slot.
  assign b_valid = replay_q || accept;
  assign b_sof   = replay_q ? 1'b1      : !trn_rsof_n;
  assign b_eof   = replay_q ? hold_eof  : !trn_reof_n;
  assign b_perr  = replay_q ? hold_perr : !trn_rerrfwd_n;
  assign b_data  = replay_q ? hold_data : trn_rd;
  assign b_rem   = replay_q ? hold_rem  : ~trn_rrem_n;
  assign b_bar   = replay_q ? hold_bar  : ~trn_rbar_hit_n;

  always_comb begin
    state_n  = state_q;
    bar_n    = bar_q;
    err_n    = err_q;
    replay_n = 1'b0;
    wr_en    = 1'b0;
    wr_entry = '0;
    tlp_inc  = 1'b0;
    drop_inc = 1'b0;
    term     = '0;
    term.eof = 1'b1;
    term.err = 1'b1;
    term.bar = bar_q;

    if (state_q == PKT && dsc) begin
      // any beat in the same cycle is discarded
      wr_en    = 1'b1;
      wr_entry = term;
      drop_inc = 1'b1;
      state_n  = IDLE;
    end else if (b_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!b_sof) begin
            drop_inc = 1'b1;
          end else if (b_eof) begin
            wr_en    = 1'b1;
            wr_entry = '{data: b_data, rem: b_rem, sof: 1'b1, eof: 1'b1,
                         err: b_perr, bar: b_bar};
            tlp_inc  = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_entry = '{data: b_data, rem: b_rem, sof: 1'b1, eof: 1'b0,
                         err: 1'b0, bar: b_bar};
            bar_n    = b_bar;
            err_n    = b_perr;
            state_n  = PKT;
          end
        end
        PKT: begin
          if (b_sof) begin
            wr_en    = 1'b1;
            wr_entry = term;
            drop_inc = 1'b1;
            replay_n = 1'b1;
            state_n  = IDLE;
          end else if (b_eof) begin
            wr_en    = 1'b1;
            wr_entry = '{data: b_data, rem: b_rem, sof: 1'b0, eof: 1'b1,
                         err: err_q | b_perr, bar: bar_q};
            tlp_inc  = 1'b1;
            state_n  = IDLE;
          end else begin
            wr_en    = 1'b1;
            wr_entry = '{data: b_data, rem: b_rem, sof: 1'b0, eof: 1'b0,
                         err: 1'b0, bar: bar_q};
            err_n    = err_q | b_perr;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  pcie_trn_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (trn_clk),
    .rst_n   (trn_reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rx_ready),
    .rd_data (head_raw),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head       = head_raw;
  assign rx_valid   = !fifo_empty;
  assign wr_do      = wr_en && !fifo_full;
  assign rd_do      = rx_valid && rx_ready;
  assign count_next = occupancy + CW'(wr_do) - CW'(rd_do);

  assign rx_data = rx_valid ? head.data : '0;
  assign rx_rem  = rx_valid ? head.rem  : '0;
  assign rx_sof  = rx_valid ? head.sof  : 1'b0;
  assign rx_eof  = rx_valid ? head.eof  : 1'b0;
  assign rx_err  = rx_valid ? head.err  : 1'b0;
  assign rx_bar  = rx_valid ? head.bar  : '0;

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q        <= IDLE;
      bar_q          <= '0;
      err_q          <= 1'b0;
      replay_q       <= 1'b0;
      hold_data      <= '0;
      hold_rem       <= '0;
      hold_eof       <= 1'b0;
      hold_perr      <= 1'b0;
      hold_bar       <= '0;
      trn_rdst_rdy_n <= 1'b1;
      trn_rnp_ok_n   <= 1'b1;
      tlp_count      <= '0;
      drop_count     <= '0;
    end else begin
      state_q  <= state_n;
      bar_q    <= bar_n;
      err_q    <= err_n;
      replay_q <= replay_n;
      if (replay_n) begin
        hold_data <= trn_rd;
        hold_rem  <= ~trn_rrem_n;
        hold_eof  <= !trn_reof_n;
        hold_perr <= !trn_rerrfwd_n;
        hold_bar  <= ~trn_rbar_hit_n;
      end
      // stop at DEPTH-2: leaves room for a terminator plus a replayed beat
      trn_rdst_rdy_n <= replay_n || (count_next >= CW'(DEPTH - 2));
      trn_rnp_ok_n   <= (CW'(DEPTH) - count_next) < CW'(NP_THRESH);
      if (tlp_inc && tlp_count != '1)   tlp_count  <= tlp_count + CNT_WIDTH'(1);
      if (drop_inc && drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pcie_trn_rx_buffer.sv
module tb_pcie_trn_rx_buffer;

  logic         trn_clk = 1'b0;
  logic         trn_reset_n;
  logic [127:0] trn_rd;
  logic [1:0]   trn_rrem_n;
  logic         trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n;
  logic [6:0]   trn_rbar_hit_n;
  logic         trn_rdst_rdy_n, trn_rnp_ok_n;
  logic [127:0] rx_data;
  logic [1:0]   rx_rem;
  logic         rx_sof, rx_eof, rx_err, rx_valid, rx_ready;
  logic [6:0]   rx_bar;
  logic [15:0]  tlp_count, drop_count;
  logic [4:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 trn_clk = ~trn_clk;

  pcie_trn_rx_buffer #(
    .DATA_WIDTH (128),
    .DEPTH      (16),
    .NP_THRESH  (4),
    .CNT_WIDTH  (16)
  ) dut (
    .trn_clk        (trn_clk),
    .trn_reset_n    (trn_reset_n),
    .trn_rd         (trn_rd),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
    .trn_rerrfwd_n  (trn_rerrfwd_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .trn_rnp_ok_n   (trn_rnp_ok_n),
    .rx_data        (rx_data),
    .rx_rem         (rx_rem),
    .rx_sof         (rx_sof),
    .rx_eof         (rx_eof),
    .rx_err         (rx_err),
    .rx_bar         (rx_bar),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tlp_count      (tlp_count),
    .drop_count     (drop_count),
    .occupancy      (occupancy)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    trn_rd         = '0;
    trn_rrem_n     = '1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    trn_rerrfwd_n  = 1'b1;
    trn_rbar_hit_n = '1;
  endtask

  task automatic drive_beat(input logic [127:0] d, input logic s, input logic e,
                            input logic p, input logic [6:0] bn, input logic [1:0] rn);
    trn_rd         = d;
    trn_rrem_n     = rn;
    trn_rsof_n     = ~s;
    trn_reof_n     = ~e;
    trn_rsrc_rdy_n = 1'b0;
    trn_rsrc_dsc_n = 1'b1;
    trn_rerrfwd_n  = ~p;
    trn_rbar_hit_n = bn;
  endtask

  // Present one beat until it is accepted (bounded), then go idle.
  task automatic send_beat(input string tag, input logic [127:0] d, input logic s, input logic e,
                           input logic p, input logic [6:0] bn, input logic [1:0] rn);
    logic acc;
    acc = 1'b0;
    drive_beat(d, s, e, p, bn, rn);
    for (int c = 0; c < 50 && !acc; c++) begin
      acc = !trn_rdst_rdy_n;
      @(posedge trn_clk); #1;
    end
    idle_inputs();
    check({"accept_", tag}, acc, 1);
  endtask

  // Check the head beat, then pop it with a one-cycle rx_ready pulse.
  task automatic expect_head(input string tag, input logic s, input logic e, input logic er,
                             input logic [6:0] bar, input logic [1:0] rem, input logic [127:0] d);
    check(tag, {rx_valid, rx_sof, rx_eof, rx_err, rx_bar, rx_rem, rx_data},
               {1'b1, s, e, er, bar, rem, d});
    rx_ready = 1'b1;
    @(posedge trn_clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   sent, got;
    logic acc;
    logic [4:0] maxocc;

    trn_reset_n = 1'b0;
    rx_ready    = 1'b0;
    idle_inputs();
    repeat (3) @(posedge trn_clk);
    #1;
    check("rst_rx", {rx_valid, rx_sof, rx_eof, rx_err, rx_bar, rx_rem, rx_data}, '0);
    check("rst_ctl", {trn_rdst_rdy_n, trn_rnp_ok_n, occupancy, tlp_count, drop_count},
                     {1'b1, 1'b1, 5'd0, 16'd0, 16'd0});
    trn_reset_n = 1'b1;
    repeat (2) @(posedge trn_clk);
    #1;
    check("ready_after_rst", {trn_rdst_rdy_n, trn_rnp_ok_n}, 2'b00);

    // single-beat TLP
    send_beat("t1", 128'h1122334455667788, 1, 1, 0, 7'b1111110, 2'b00);
    check("t1_visible", {rx_valid, tlp_count, occupancy}, {1'b1, 16'd1, 5'd1});
    expect_head("t1_head", 1, 1, 0, 7'b0000001, 2'b11, 128'h1122334455667788);

    // backpressure: 20-beat TLP with consumer stalled
    sent   = 0;
    maxocc = '0;
    for (int c = 0; c < 25; c++) begin
      drive_beat(128'hB000 + 128'(sent), sent == 0, sent == 19, 0, 7'b1111101, 2'b00);
      acc = !trn_rdst_rdy_n;
      @(posedge trn_clk); #1;
      if (acc) sent++;
      if (occupancy > maxocc) maxocc = occupancy;
      if (occupancy == 5'd12) check("bp_np_at12", trn_rnp_ok_n, 0);
      if (occupancy == 5'd13) check("bp_at13", {trn_rnp_ok_n, trn_rdst_rdy_n}, 2'b10);
    end
    check("bp_stalled", {sent[7:0], occupancy, trn_rdst_rdy_n, trn_rnp_ok_n},
                        {8'd14, 5'd14, 1'b1, 1'b1});
    got      = 0;
    rx_ready = 1'b1;
    for (int c = 0; c < 200 && got < 20; c++) begin
      if (sent < 20) drive_beat(128'hB000 + 128'(sent), sent == 0, sent == 19, 0, 7'b1111101, 2'b00);
      else idle_inputs();
      acc = !trn_rdst_rdy_n && (sent < 20);
      if (rx_valid) begin
        check("bp_beat", {rx_sof, rx_eof, rx_bar, rx_data},
                         {got == 0, got == 19, 7'b0000010, 128'hB000 + 128'(got)});
        got++;
      end
      @(posedge trn_clk); #1;
      if (acc) sent++;
      if (occupancy > maxocc) maxocc = occupancy;
    end
    rx_ready = 1'b0;
    idle_inputs();
    check("bp_drained", {got[7:0], sent[7:0], occupancy, maxocc, tlp_count},
                        {8'd20, 8'd20, 5'd0, 5'd14, 16'd2});

    // poisoned 4-beat TLP
    send_beat("p0", 128'hC0, 1, 0, 0, 7'b1111011, 2'b00);
    send_beat("p1", 128'hC1, 0, 0, 1, 7'b1111111, 2'b00);
    send_beat("p2", 128'hC2, 0, 0, 0, 7'b1111111, 2'b00);
    send_beat("p3", 128'hC3, 0, 1, 0, 7'b1111111, 2'b01);
    check("p_cnt", {tlp_count, occupancy}, {16'd3, 5'd4});
    expect_head("p_h0", 1, 0, 0, 7'b0000100, 2'b11, 128'hC0);
    expect_head("p_h1", 0, 0, 0, 7'b0000100, 2'b11, 128'hC1);
    expect_head("p_h2", 0, 0, 0, 7'b0000100, 2'b11, 128'hC2);
    expect_head("p_h3", 0, 1, 1, 7'b0000100, 2'b10, 128'hC3);

    // discontinue on the second beat, then an intact TLP
    send_beat("d0", 128'hD0, 1, 0, 0, 7'b0111111, 2'b00);
    drive_beat(128'hD1, 0, 0, 0, 7'b1111111, 2'b00);
    trn_rsrc_dsc_n = 1'b0;
    @(posedge trn_clk); #1;
    idle_inputs();
    check("d_cnt", {drop_count, occupancy}, {16'd1, 5'd2});
    send_beat("e0", 128'hE0, 1, 0, 0, 7'b1101111, 2'b00);
    send_beat("e1", 128'hE1, 0, 1, 0, 7'b1111111, 2'b00);
    check("d_tlp", tlp_count, 16'd4);
    expect_head("d_h0",   1, 0, 0, 7'b1000000, 2'b11, 128'hD0);
    expect_head("d_term", 0, 1, 1, 7'b1000000, 2'b00, 128'h0);
    expect_head("e_h0",   1, 0, 0, 7'b0010000, 2'b11, 128'hE0);
    expect_head("e_h1",   0, 1, 0, 7'b0010000, 2'b11, 128'hE1);

    // missing eof: sof, data, sof, eof
    send_beat("mA", 128'hA0, 1, 0, 0, 7'b1111110, 2'b00);
    send_beat("mB", 128'hA1, 0, 0, 0, 7'b1111111, 2'b00);
    send_beat("mC", 128'hA2, 1, 0, 0, 7'b1111101, 2'b00);
    check("m_hold", {trn_rdst_rdy_n, occupancy}, {1'b1, 5'd3});
    send_beat("mD", 128'hA3, 0, 1, 0, 7'b1111111, 2'b00);
    check("m_cnt", {tlp_count, drop_count, occupancy}, {16'd5, 16'd2, 5'd5});
    expect_head("m_hA",   1, 0, 0, 7'b0000001, 2'b11, 128'hA0);
    expect_head("m_hB",   0, 0, 0, 7'b0000001, 2'b11, 128'hA1);
    expect_head("m_term", 0, 1, 1, 7'b0000001, 2'b00, 128'h0);
    expect_head("m_hC",   1, 0, 0, 7'b0000010, 2'b11, 128'hA2);
    expect_head("m_hD",   0, 1, 0, 7'b0000010, 2'b11, 128'hA3);

    // stray beat in IDLE is dropped; discontinue in IDLE is ignored
    send_beat("stray", 128'hF0, 0, 1, 0, 7'b1111111, 2'b00);
    trn_rsrc_dsc_n = 1'b0;
    @(posedge trn_clk); #1;
    idle_inputs();
    check("stray_cnt", {drop_count, tlp_count, occupancy, rx_valid}, {16'd3, 16'd5, 5'd0, 1'b0});

    // reset in the middle of a TLP
    send_beat("g0", 128'h60, 1, 0, 0, 7'b1111110, 2'b00);
    send_beat("g1", 128'h61, 0, 0, 0, 7'b1111111, 2'b00);
    check("g_occ", occupancy, 5'd2);
    @(posedge trn_clk); #2;
    trn_reset_n = 1'b0;
    #1;
    check("mid_rst_rx", {rx_valid, rx_sof, rx_eof, rx_err, rx_bar, rx_rem, rx_data}, '0);
    check("mid_rst_ctl", {trn_rdst_rdy_n, trn_rnp_ok_n, occupancy, tlp_count, drop_count},
                         {1'b1, 1'b1, 5'd0, 16'd0, 16'd0});
    @(posedge trn_clk); #1;
    trn_reset_n = 1'b1;
    repeat (2) @(posedge trn_clk);
    #1;
    send_beat("h0", 128'hFEDCBA98765432100123456789ABCDEF, 1, 1, 1, 7'b1011111, 2'b10);
    check("h_cnt", {tlp_count, drop_count, occupancy}, {16'd1, 16'd0, 5'd1});
    expect_head("h_head", 1, 1, 1, 7'b0100000, 2'b01, 128'hFEDCBA98765432100123456789ABCDEF);
    send_beat("j0", 128'h70, 1, 0, 0, 7'b1110111, 2'b00);
    send_beat("j1", 128'h71, 0, 1, 0, 7'b1111111, 2'b01);
    check("j_cnt", {tlp_count, drop_count}, {16'd2, 16'd0});
    expect_head("j_h0", 1, 0, 0, 7'b0001000, 2'b11, 128'h70);
    expect_head("j_h1", 0, 1, 0, 7'b0001000, 2'b10, 128'h71);
    check("final_empty", {rx_valid, occupancy}, {1'b0, 5'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
